// File: rtl/samm_pkg.sv
//------------------------------------------------------------------------------
// Module : samm_pkg
// Brief  : Shared widths and FSM encoding for the result RAM write path.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package samm_pkg;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 20;
    localparam int DEF_NUM_RES = 16;
    localparam int RES16_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } state_t;
endpackage

`default_nettype wire

// File: rtl/sat16.sv
//------------------------------------------------------------------------------
// Module : sat16
// Brief  : Combinational signed saturator from ACC_W bits to 16 bits.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat16
    import samm_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]   i_acc,
    output logic [RES16_W-1:0] o_res16
);

    // Value fits in 16 signed bits only when every bit from 15 upward matches
    logic [ACC_W-RES16_W:0] w_top;
    assign w_top = i_acc[ACC_W-1:RES16_W-1];

    always_comb begin
        o_res16 = i_acc[RES16_W-1:0];
        if ((|w_top) && !(&w_top)) begin
            o_res16 = i_acc[ACC_W-1] ? {1'b1, {(RES16_W-1){1'b0}}}
                                     : {1'b0, {(RES16_W-1){1'b1}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/result_ram_writer.sv
//------------------------------------------------------------------------------
// Module : result_ram_writer
// Brief  : Stores a run of NUM_RES accumulator results as byte pairs through
//          the two write ports of the result RAM. RESULT_SAT_EN selects
//          16-bit saturation instead of truncation.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_ram_writer
    import samm_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int NUM_RES = DEF_NUM_RES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic              wrap_err,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [ACC_W-1:0]  res_data,
    output logic              wen1,
    output logic              wen2,
    output logic [ADDR_W-1:0] ad1,
    output logic [ADDR_W-1:0] ad2,
    output logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] wd2
);

    localparam int CNT_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
    localparam int SUM_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_RES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_count;
    logic                r_done;
    logic                r_wrap;
    logic                r_wen;
    logic [ADDR_W-1:0]   r_ad1;
    logic [ADDR_W-1:0]   r_ad2;
    logic [DATA_W-1:0]   r_wd1;
    logic [DATA_W-1:0]   r_wd2;
    logic                w_load;
    logic                w_hs;
    logic [RES16_W-1:0]  w_res16;
    logic [SUM_W-1:0]    w_sum1;
    logic [SUM_W-1:0]    w_sum2;
    logic                w_wrap;

`ifdef RESULT_SAT_EN
    sat16 #(
        .ACC_W (ACC_W)
    ) u_sat16 (
        .i_acc   (res_data),
        .o_res16 (w_res16)
    );
`else
    assign w_res16 = res_data[RES16_W-1:0];
    logic w_unused;
    assign w_unused = ^res_data[ACC_W-1:RES16_W];
`endif

    // One extra carry bit exposes a wrap past the top of the address space
    assign w_sum1 = {1'b0, r_base} + SUM_W'({r_count, 1'b0});
    assign w_sum2 = w_sum1 + SUM_W'(1);
    assign w_wrap = w_sum1[ADDR_W] | w_sum2[ADDR_W];

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_hs         = 1'b0;
        res_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                res_ready = 1'b1;
                busy      = 1'b1;
                if (res_valid) begin
                    w_hs = 1'b1;
                    if (r_count == LAST_CNT) begin
                        w_state_next = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                busy         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_wen   <= 1'b0;
            r_ad1   <= '0;
            r_ad2   <= '0;
            r_wd1   <= '0;
            r_wd2   <= '0;
        end else begin
            r_done <= (r_state == ST_LAST);
            r_wen  <= w_hs;
            if (w_load) begin
                r_base  <= base_addr;
                r_count <= '0;
                r_wrap  <= 1'b0;
            end
            // Address/data registers only move on a handshake and hold otherwise
            if (w_hs) begin
                r_ad1   <= w_sum1[ADDR_W-1:0];
                r_ad2   <= w_sum2[ADDR_W-1:0];
                r_wd1   <= w_res16[DATA_W-1:0];
                r_wd2   <= w_res16[2*DATA_W-1:DATA_W];
                r_count <= r_count + CNT_W'(1);
                if (w_wrap) begin
                    r_wrap <= 1'b1;
                end
            end
        end
    end

    assign done     = r_done;
    assign wrap_err = r_wrap;
    assign wen1     = r_wen;
    assign wen2     = r_wen;
    assign ad1      = r_ad1;
    assign ad2      = r_ad2;
    assign wd1      = r_wd1;
    assign wd2      = r_wd2;

endmodule

`default_nettype wire

// File: doc/result_ram_writer.md
Name: result_ram_writer

Overview:
Write-side counterpart to the operand RAM read path.
- Accepts the systolic array's result stream, one accumulator value per handshake.
- Splits each result into low and high bytes.
- Writes both bytes in the same cycle through the two write ports of the result RAM (wen1/wen2, ad1/ad2, wd1/wd2).
- Sits between the array output drain and the result memory. One run stores one full NUM_RES-result matrix starting at a programmable base address.

Parameters:
ADDR_W, 10, RAM address width (1024 byte locations)
DATA_W, 8, RAM byte width
ACC_W, 20, array accumulator width on res_data
NUM_RES, 16, results per run (N*N, N=4)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  begin run; sampled only when idle
base_addr  in  ADDR_W  first byte address of run
busy  out  1  run in progress
done  out  1  one-cycle pulse, run complete
wrap_err  out  1  sticky: some address in run wrapped past 2^ADDR_W-1
res_valid  in  1  result available
res_ready  out  1  writer can accept
res_data  in  ACC_W  signed accumulator result
wen1  out  1  write enable, port 1 (low byte)
wen2  out  1  write enable, port 2 (high byte)
ad1  out  ADDR_W  port 1 address
ad2  out  ADDR_W  port 2 address
wd1  out  DATA_W  port 1 data
wd2  out  DATA_W  port 2 data

Behaviour:
- Reset: synchronous, active-high; clk and rst as in the RAM. All outputs 0, state IDLE, count 0, wrap_err 0.
- FSM states: IDLE, RUN, LAST.
- IDLE:
  - res_ready=0, busy=0; res_valid ignored.
  - start=1 -> latch base_addr, clear count and wrap_err, go RUN.
- RUN:
  - res_ready=1, busy=1.
  - Handshake (res_valid & res_ready) in cycle t -> in cycle t+1: wen1=wen2=1, ad1=base+2*count, ad2=ad1+1, wd1=res16[7:0], wd2=res16[15:8]; count increments.
  - All address arithmetic is modulo 2^ADDR_W. wrap_err is set if ad1 or ad2 wraps.
  - No handshake -> wen1=wen2=0 next cycle (one strobe per result, never repeated).
  - Handshake with count==NUM_RES-1 -> go LAST.
- LAST:
  - res_ready=0, busy=1; the final write strobe is high this cycle.
  - Next cycle: state IDLE, done=1 for exactly one cycle, busy=0.
- start is ignored while busy. start in the done cycle is accepted normally.
- Write outputs are registered; latency from handshake to RAM strobe is 1 cycle. Sustained throughput is 1 result/cycle.
- res16 (without the optional feature) = res_data[15:0], truncation.
- rst mid-run: no further strobes from the next edge; done is not pulsed; partially written RAM contents are left as is.
- ad1/ad2/wd1/wd2 hold their last values when wen is low.

Optional Feature:
- Macro: RESULT_SAT_EN.
- Defined: res16 = res_data saturated to signed 16-bit. Values >32767 become 0x7FFF; values <-32768 become 0x8000; others pass through. Purely combinational ahead of the output register; latency unchanged.
- Undefined: truncation to res_data[15:0].

Decomposition:
- Package samm_pkg: ADDR_W/DATA_W/ACC_W defaults, FSM state encoding constants, RES16_W=16.
- Sub-module sat16: combinational ACC_W->16 signed saturator, instantiated only under RESULT_SAT_EN.

Test Plan:
- base_addr=0, 16 back-to-back results res_data=0x00100+k -> mem[2k]=k, mem[2k+1]=0x01. Strobes on 16 consecutive cycles starting 1 cycle after the first handshake; done 2 cycles after the last handshake; wrap_err=0.
- Same run with res_valid toggling every other cycle -> exactly 16 single-cycle strobe pairs, no duplicates, identical memory image.
- base_addr=1016, 16 results -> 5th result writes ad1=0, ad2=1; wrap_err=1 until the next start; the next start clears it.
- rst asserted after 5 accepted results -> wen1=wen2=0 from the next cycle, busy=0, no done; a following start with base_addr=0x100 writes from 0x100.
- start pulsed mid-run with base_addr=0x200 -> ignored; addresses continue from the original base.
- res_data=0x7FFFF and 0x80000 -> with RESULT_SAT_EN: bytes FF/7F and 00/80; without: FF/FF and 00/00.
